dm_param: RTL and testbench
===========================

// Module: dm_param
// PURPOSE
//  Parametrised data memory for the pipelined MIPS datapath (MEM stage): byte-addressed,
//  32-bit data, byte/halfword/word loads and stores with sign/zero extension.
//  One-cycle registered read, misalignment detection, post-reset clear sweep with busy flag.
//  Successor of the fixed 4 KB word-only data memory; top level stalls the pipe on busy.
// PARAMETERS
//  ADDR_W      12  byte-address width used; DEPTH = 2**(ADDR_W-2) 32-bit words (12 -> 1024 words)
//  INIT_CLEAR  1   1: zero all words after reset (busy sweep); 0: no sweep, contents kept, busy=0
// PORTS
//  clk        in   1       clock; all state updates on posedge
//  rst        in   1       synchronous, active-high reset
//  addr       in   ADDR_W  byte address; word index = addr[ADDR_W-1:2], lane = addr[1:0]
//  din        in   32      store data, right-justified (sb uses din[7:0], sh uses din[15:0])
//  we         in   1       store enable
//  re         in   1       load enable
//  size       in   2       00 byte, 01 half, 10 word, 11 reserved (treated as word)
//  sign_ext   in   1       loads only: 1 sign-extend, 0 zero-extend
//  dout       out  32      load result, registered
//  dout_valid out  1       1-cycle pulse: dout updated by a load issued the previous cycle
//  misalign   out  1       1-cycle pulse: access issued the previous cycle was misaligned
//  busy       out  1       clear sweep in progress; we/re ignored while high
// BEHAVIOUR
//  - Reset (rst=1 at posedge): dout=0, dout_valid=0, misalign=0, clear index=0;
//    INIT_CLEAR=1 -> state CLEAR, busy=1; INIT_CLEAR=0 -> state READY, busy=0.
//  - FSM CLEAR: write 0 to word[idx], idx++ each cycle; after word DEPTH-1 -> READY.
//    busy high exactly DEPTH cycles after the reset cycle. rst mid-sweep restarts at idx 0.
//  - FSM READY: accesses honoured; stays READY until rst.
//  - Little-endian lanes: byte at lane k = word[8k+7:8k]; half at lane 0 = [15:0], lane 2 = [31:16].
//  - Alignment: half needs addr[0]=0; word needs addr[1:0]=00. Byte always aligned.
//  - Misaligned access (we or re): no memory write, dout unchanged, dout_valid=0,
//    misalign=1 next cycle.
//  - Store (we, READY, aligned): only the selected byte lanes written at the posedge; other lanes kept.
//  - Load (re, READY, aligned): lanes extracted, extended to 32 bits per sign_ext;
//    dout and dout_valid=1 next cycle. Word loads ignore sign_ext.
//  - we and re same cycle, same word: load returns pre-store contents (read-before-write).
//  - No load issued: dout holds previous value, dout_valid=0.
//  - addr bits >= ADDR_W do not exist at the port; index wraps naturally within DEPTH.
//  - While busy: we/re ignored, no misalign, no dout_valid.
// STRUCTURE
//  - dm_pkg: SZ_BYTE/SZ_HALF/SZ_WORD encodings, FSM state constants (ST_CLEAR, ST_READY).
//  - Sub-module dm_load_fmt (combinational): {word, lane, size, sign_ext} -> 32-bit extended
//    load value; also used by bench as reference model.
//  - Top: storage array, byte-enable generation, clear FSM/counter, output registers.
// TESTING
//  1 rst 1 cycle, ADDR_W=12 -> busy=1 for 1024 cycles then 0; lw 0x0FC -> dout=0, valid next cycle.
//  2 sw 0x010 din=0xDEADBEEF; lw 0x010 -> dout=0xDEADBEEF, dout_valid pulse 1 cycle.
//  3 from 2: lb 0x013 -> 0xFFFFFFDE; lbu 0x013 -> 0x000000DE; lh 0x012 -> 0xFFFFDEAD; lhu 0x010 -> 0x0000BEEF.
//  4 sb 0x011 din=0x12345655 -> lw 0x010 = 0xDEAD55EF; sh 0x012 din=0x0000CAFE -> lw 0x010 = 0xCAFE55EF.
//  5 sw 0x012 din=0x11111111 -> misalign pulse, dout_valid=0; lw 0x010 still 0xCAFE55EF; lh 0x011 -> misalign.
//  6 same cycle sw+lw 0x010 din=0x0 -> dout=0xCAFE55EF, next lw -> 0; rst at sweep idx 500 -> busy
//    another full 1024 cycles, then lw 0x010 = 0.

Source files
------------

// File: rtl/dm_pkg.sv
// Shared encodings for the parametrised data memory: access sizes, FSM states and the
// alignment rule used by the top level.
package dm_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_READY = 1'b1
    } dm_state_e;

    // Reserved size 2'b11 behaves as a word access.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
        case (size)
            SZ_BYTE: return 1'b0;
            SZ_HALF: return lane[0];
            default: return lane != 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/dm_load_fmt.sv
// Load formatter: selects the addressed byte/halfword lane of a memory word and extends it
// to 32 bits.
module dm_load_fmt
    import dm_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    output logic [31:0] data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = 8'(word >> {lane, 3'b000});
        half_sel = lane[1] ? word[31:16] : word[15:0];
        data     = word;
        case (size)
            SZ_BYTE: data = {{24{sign_ext & byte_sel[7]}}, byte_sel};
            SZ_HALF: data = {{16{sign_ext & half_sel[15]}}, half_sel};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/dm_param.sv
// Byte-addressed 32-bit data memory with sized loads/stores, misalignment detection and an
// optional post-reset clear sweep that holds busy high until every word is zeroed.
module dm_param
    import dm_pkg::*;
#(
    parameter int unsigned ADDR_W     = 12,
    parameter bit          INIT_CLEAR = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       din,
    input  logic              we,
    input  logic              re,
    input  logic [1:0]        size,
    input  logic              sign_ext,
    output logic [31:0]       dout,
    output logic              dout_valid,
    output logic              misalign,
    output logic              busy
);

    localparam int unsigned IDX_W = ADDR_W - 2;
    localparam int unsigned DEPTH = 2 ** IDX_W;

    logic [31:0] mem [DEPTH];

    dm_state_e        state_q, state_d;
    logic [IDX_W-1:0] clr_idx_q, clr_idx_d;
    logic [31:0]      dout_q;
    logic             dout_valid_q, misalign_q;

    logic [IDX_W-1:0] word_idx;
    logic [1:0]       lane;
    logic             ready, mis, store, load;
    logic [3:0]       be;
    logic [31:0]      wdata, rword, ldata;

    assign word_idx = addr[ADDR_W-1:2];
    assign lane     = addr[1:0];
    // Combinational array read feeds the output register, so a same-cycle store is not yet
    // visible and a colliding load returns the pre-store word.
    assign rword    = mem[word_idx];

    dm_load_fmt u_load_fmt (
        .word     (rword),
        .lane     (lane),
        .size     (size),
        .sign_ext (sign_ext),
        .data     (ldata)
    );

    always_comb begin
        ready = (state_q == ST_READY) && !rst;
        mis   = is_misaligned(size, lane);
        store = ready && we && !mis;
        load  = ready && re && !mis;

        be    = 4'b1111;
        wdata = din;
        case (size)
            SZ_BYTE: begin
                be    = 4'b0001 << lane;
                wdata = {4{din[7:0]}};
            end
            SZ_HALF: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wdata = {2{din[15:0]}};
            end
            default: ;
        endcase

        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        if (state_q == ST_CLEAR) begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (&clr_idx_q) begin
                state_d = ST_READY;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= INIT_CLEAR ? ST_CLEAR : ST_READY;
            clr_idx_q    <= '0;
            dout_q       <= '0;
            dout_valid_q <= 1'b0;
            misalign_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            clr_idx_q    <= clr_idx_d;
            dout_valid_q <= load;
            misalign_q   <= ready && (we || re) && mis;
            if (load) begin
                dout_q <= ldata;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && state_q == ST_CLEAR) begin
            mem[clr_idx_q] <= '0;
        end else if (store) begin
            for (int k = 0; k < 4; k++) begin
                if (be[k]) begin
                    mem[word_idx][8*k +: 8] <= wdata[8*k +: 8];
                end
            end
        end
    end

    assign dout       = dout_q;
    assign dout_valid = dout_valid_q;
    assign misalign   = misalign_q;
    assign busy       = (state_q == ST_CLEAR);

endmodule

// File: tb/tb_dm_param.sv
// Bench for dm_param: directed steps plus random traffic checked against a byte-array
// reference memory.
module tb_dm_param;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] addr = '0;
    logic [31:0] din = '0;
    logic        we = 1'b0;
    logic        re = 1'b0;
    logic [1:0]  size = 2'b10;
    logic        sign_ext = 1'b0;
    logic [31:0] dout;
    logic        dout_valid, misalign, busy;

    int          checks = 0;
    int          failures = 0;
    logic [7:0]  mdl [4096];
    logic [31:0] mdl_dout = '0;

    always #5 clk = ~clk;

    dm_param #(
        .ADDR_W     (12),
        .INIT_CLEAR (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .addr       (addr),
        .din        (din),
        .we         (we),
        .re         (re),
        .size       (size),
        .sign_ext   (sign_ext),
        .dout       (dout),
        .dout_valid (dout_valid),
        .misalign   (misalign),
        .busy       (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_clear();
        for (int i = 0; i < 4096; i++) mdl[i] = 8'h00;
    endtask

    function automatic int nbytes(input logic [1:0] sz);
        return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    endfunction

    function automatic bit model_mis(input logic [11:0] a, input logic [1:0] sz);
        int n = nbytes(sz);
        if (n == 2) return a[0];
        if (n == 4) return a[1:0] != 2'b00;
        return 1'b0;
    endfunction

    function automatic logic [31:0] model_load(input logic [11:0] a, input logic [1:0] sz,
                                               input logic sx);
        int n = nbytes(sz);
        logic [31:0] v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = mdl[(int'(a) + i) % 4096];
        for (int i = 8 * n; i < 32; i++) v[i] = sx & v[8*n-1];
        return v;
    endfunction

    // Issue one access for a cycle, update the reference model, check the registered outputs.
    task automatic op(input bit w, input bit r, input logic [11:0] a, input logic [31:0] d,
                      input logic [1:0] sz, input bit sx, input string tag);
        bit          mis;
        logic [31:0] ld;
        int          n;
        mis = model_mis(a, sz);
        ld  = model_load(a, sz, sx);
        n   = nbytes(sz);
        we = w; re = r; addr = a; din = d; size = sz; sign_ext = sx;
        tick();
        we = 1'b0; re = 1'b0;
        if (w && !mis) begin
            for (int i = 0; i < n; i++) mdl[(int'(a) + i) % 4096] = d[8*i +: 8];
        end
        if (r && !mis) mdl_dout = ld;
        check({tag, ".dout"}, dout, mdl_dout);
        check({tag, ".valid"}, {31'b0, dout_valid}, {31'b0, r && !mis});
        check({tag, ".misalign"}, {31'b0, misalign}, {31'b0, (w || r) && mis});
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        mdl_dout = '0;
    endtask

    // Hammer aligned word traffic while busy; none of it may take effect.
    task automatic wait_sweep(input string tag);
        int n = 0;
        int bad = 0;
        we = 1'b1; re = 1'b1; addr = 12'h000; din = 32'hDEADBEEF; size = 2'b10;
        while (busy && n < 3000) begin
            tick();
            n++;
            if (dout_valid || misalign) bad++;
        end
        we = 1'b0; re = 1'b0;
        check({tag, ".busy_cycles"}, n, 1024);
        check({tag, ".quiet"}, bad, 0);
        check({tag, ".dout_held"}, dout, 32'h0);
        model_clear();
    endtask

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [11:0] ra;
        model_clear();
        tick();

        // 1: reset, sweep, read back cleared memory
        do_reset();
        check("rst.busy", {31'b0, busy}, 32'd1);
        check("rst.dout", dout, 32'h0);
        check("rst.valid", {31'b0, dout_valid}, 32'd0);
        check("rst.misalign", {31'b0, misalign}, 32'd0);
        wait_sweep("sweep1");
        check("sweep1.busy_low", {31'b0, busy}, 32'd0);
        op(0, 1, 12'h0FC, 32'h0, 2'b10, 0, "lw0fc");
        op(0, 1, 12'h000, 32'h0, 2'b10, 0, "lw000");

        // 2: word store / load, one-cycle valid pulse
        op(1, 0, 12'h010, 32'hDEADBEEF, 2'b10, 0, "sw010");
        op(0, 1, 12'h010, 32'h0, 2'b10, 0, "lw010");
        check("lw010.lit", dout, 32'hDEADBEEF);
        op(0, 0, 12'h010, 32'h0, 2'b10, 0, "idle1");

        // 3: sub-word loads with extension
        op(0, 1, 12'h013, 32'h0, 2'b00, 1, "lb013");
        check("lb013.lit", dout, 32'hFFFFFFDE);
        op(0, 1, 12'h013, 32'h0, 2'b00, 0, "lbu013");
        check("lbu013.lit", dout, 32'h000000DE);
        op(0, 1, 12'h012, 32'h0, 2'b01, 1, "lh012");
        check("lh012.lit", dout, 32'hFFFFDEAD);
        op(0, 1, 12'h010, 32'h0, 2'b01, 0, "lhu010");
        check("lhu010.lit", dout, 32'h0000BEEF);

        // 4: partial stores keep other lanes
        op(1, 0, 12'h011, 32'h12345655, 2'b00, 0, "sb011");
        op(0, 1, 12'h010, 32'h0, 2'b10, 0, "lw010b");
        check("lw010b.lit", dout, 32'hDEAD55EF);
        op(1, 0, 12'h012, 32'h0000CAFE, 2'b01, 0, "sh012");
        op(0, 1, 12'h010, 32'h0, 2'b10, 0, "lw010c");
        check("lw010c.lit", dout, 32'hCAFE55EF);

        // 5: misaligned accesses
        op(1, 0, 12'h012, 32'h11111111, 2'b10, 0, "sw012mis");
        check("sw012mis.lit", {31'b0, misalign}, 32'd1);
        op(0, 1, 12'h010, 32'h0, 2'b10, 0, "lw010d");
        check("lw010d.lit", dout, 32'hCAFE55EF);
        op(0, 1, 12'h011, 32'h0, 2'b01, 1, "lh011mis");
        check("lh011mis.lit", {31'b0, misalign}, 32'd1);
        op(0, 0, 12'h000, 32'h0, 2'b10, 0, "idle2");

        // 6: read-before-write on a colliding store/load
        op(1, 1, 12'h010, 32'h0, 2'b10, 0, "swlw010");
        check("swlw010.lit", dout, 32'hCAFE55EF);
        op(0, 1, 12'h010, 32'h0, 2'b10, 0, "lw010e");
        check("lw010e.lit", dout, 32'h0);

        // Random traffic, mostly within a small window so stores and loads collide
        for (int i = 0; i < 400; i++) begin
            ra = ($urandom_range(0, 3) != 0) ? 12'($urandom_range(0, 31)) : 12'($urandom());
            op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), ra, $urandom(),
               2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), "rand");
        end

        // 6 (cont.): reset in the middle of a sweep restarts it
        op(1, 0, 12'h010, 32'h5A5A5A5A, 2'b10, 0, "sw010pre");
        do_reset();
        for (int i = 0; i < 500; i++) tick();
        check("midsweep.busy", {31'b0, busy}, 32'd1);
        do_reset();
        wait_sweep("sweep2");
        op(0, 1, 12'h010, 32'h0, 2'b10, 0, "lw010f");
        check("lw010f.lit", dout, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
